// File: rtl/peripheral_bus_hub.sv
// Peripheral bus hub: decodes chipset bus cycles onto up to CHANNELS
// peripheral cores, stretches the cycle with wait states until the selected
// device is ready (or a timeout expires), and returns registered read data.
module peripheral_bus_hub #(
  parameter int                     CHANNELS  = 8,
  parameter logic [20*CHANNELS-1:0] CH_BASE   = {CHANNELS{20'h0}},
  parameter logic [20*CHANNELS-1:0] CH_MASK   = {CHANNELS{20'hFFFE0}},
  parameter logic [CHANNELS-1:0]    CH_MEMORY = {CHANNELS{1'b0}},
  parameter logic [4*CHANNELS-1:0]  CH_WAIT   = {CHANNELS{4'd0}},
  parameter logic [7:0]             TIMEOUT   = 8'd255
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    io_read_n,
  input  logic                    io_write_n,
  input  logic                    memory_read_n,
  input  logic                    memory_write_n,
  input  logic                    address_enable_n,
  input  logic [19:0]             address,
  input  logic [CHANNELS-1:0]     channel_ready,
  input  logic [8*CHANNELS-1:0]   channel_data_in,
  output logic [CHANNELS-1:0]     chip_select_n,
  output logic [7:0]              data_bus_out,
  output logic                    data_bus_out_from_chipset,
  output logic                    io_channel_ready,
  output logic                    timeout_pulse
);

  localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [SEL_W-1:0]    sel;
  logic                is_read;
  logic [3:0]          wcnt;
  logic [7:0]          tcnt;
  logic [7:0]          rdata;

  logic                io_active;
  logic                mem_active;
  logic [CHANNELS-1:0] hit;
  logic                any_hit;
  logic [SEL_W-1:0]    win;

  logic [3:0]          win_wait;
  logic                win_ready;
  logic                win_read;
  logic [7:0]          win_data;
  logic                sel_strobe;
  logic                sel_ready;
  logic [7:0]          sel_data;

  logic [3:0]          wcnt_dec;
  logic                load_access;
  logic                capture;
  logic [7:0]          capture_data;
  logic                timeout_hit;

  assign io_active  = ~io_read_n | ~io_write_n;
  assign mem_active = ~memory_read_n | ~memory_write_n;

  // Address match per channel, qualified by the strobe pair of its space.
  always_comb begin
    hit = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      hit[k] = address_enable_n &&
               (((address ^ CH_BASE[20*k +: 20]) & CH_MASK[20*k +: 20]) == 20'h0) &&
               (CH_MEMORY[k] ? mem_active : io_active);
    end
  end

  // Priority encode the hits so the lowest-numbered channel wins.
  always_comb begin
    any_hit = 1'b0;
    win     = '0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      if (hit[k]) begin
        any_hit = 1'b1;
        win     = SEL_W'(k);
      end
    end
  end

  assign win_wait   = CH_WAIT[4*int'(win) +: 4];
  assign win_ready  = channel_ready[win];
  assign win_data   = channel_data_in[8*int'(win) +: 8];
  assign win_read   = CH_MEMORY[win] ? ~memory_read_n : ~io_read_n;

  assign sel_strobe = CH_MEMORY[sel] ? mem_active : io_active;
  assign sel_ready  = channel_ready[sel];
  assign sel_data   = channel_data_in[8*int'(sel) +: 8];

  // The wait count seen after this cycle's decrement; reaching zero means the
  // minimum wait has been served by the end of this cycle.
  assign wcnt_dec = (wcnt != 4'd0) ? (wcnt - 4'd1) : 4'd0;

  // Next-state logic and the capture/timeout decisions for this cycle.
  always_comb begin
    state_next   = state;
    load_access  = 1'b0;
    capture      = 1'b0;
    capture_data = sel_data;
    timeout_hit  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (any_hit) begin
          load_access = 1'b1;
          if ((win_wait == 4'd0) && win_ready) begin
            state_next   = ST_DONE;
            capture      = win_read;
            capture_data = win_data;
          end else begin
            state_next = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (!sel_strobe) begin
          state_next = ST_IDLE;
        end else if ((wcnt_dec == 4'd0) && sel_ready) begin
          state_next = ST_DONE;
          capture    = is_read;
        end else if (tcnt == (TIMEOUT - 8'd1)) begin
          state_next  = ST_DONE;
          timeout_hit = 1'b1;
        end
      end
      ST_DONE: begin
        if (!sel_strobe) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State register plus the access context, counters and read-data latch.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= ST_IDLE;
      sel           <= '0;
      is_read       <= 1'b0;
      wcnt          <= 4'd0;
      tcnt          <= 8'd0;
      rdata         <= 8'h00;
      timeout_pulse <= 1'b0;
    end else begin
      state         <= state_next;
      timeout_pulse <= timeout_hit;
      if (load_access) begin
        sel     <= win;
        is_read <= win_read;
        wcnt    <= win_wait;
        tcnt    <= 8'd0;
      end else if (state == ST_WAIT) begin
        wcnt <= wcnt_dec;
        if (tcnt != 8'hFF) begin
          tcnt <= tcnt + 8'd1;
        end
      end
      if (capture) begin
        rdata <= capture_data;
      end else if (timeout_hit && is_read) begin
        rdata <= 8'hFF;
      end
    end
  end

  // Chip select follows the live decode in IDLE and the held selection after.
  always_comb begin
    chip_select_n = '1;
    if (state == ST_IDLE) begin
      if (any_hit) begin
        chip_select_n[win] = 1'b0;
      end
    end else if (sel_strobe) begin
      chip_select_n[sel] = 1'b0;
    end
  end

  assign io_channel_ready          = (state != ST_WAIT);
  assign data_bus_out_from_chipset = is_read && ((state == ST_WAIT) || (state == ST_DONE));
  assign data_bus_out              = (is_read && (state == ST_DONE)) ? rdata : 8'h00;

endmodule
